// File: rtl/cipher_block_packer.sv
// rtl/cipher_block_packer.sv - packs a byte stream into 128-bit plaintext blocks with optional PKCS#7 padding
module cipher_block_packer #(
  parameter bit PAD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

  logic [127:0] buf_q, buf_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         pad_pending_q, pad_pending_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;

  logic [127:0] blk;
  logic [7:0]   fill;
  logic         accept;
  logic         out_fire;

  assign in_ready  = rst && !out_valid_q && !pad_pending_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    accept   = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
    // Lanes past the incoming byte always take the fill value, so stale bytes never leak out.
    fill     = PAD_EN ? {4'd0, 4'd15 - cnt_q} : 8'h00;
    blk      = '0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) < cnt_q) begin
        blk[127-8*i -: 8] = buf_q[127-8*i -: 8];
      end else if (4'(i) == cnt_q) begin
        blk[127-8*i -: 8] = in_data;
      end else begin
        blk[127-8*i -: 8] = fill;
      end
    end

    buf_d         = buf_q;
    cnt_d         = cnt_q;
    pad_pending_d = pad_pending_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      if (pad_pending_q) begin
        out_data_d    = {16{8'h10}};
        out_valid_d   = 1'b1;
        out_last_d    = 1'b1;
        pad_pending_d = 1'b0;
      end
    end

    if (accept) begin
      buf_d = blk;
      if (in_last || cnt_q == 4'd15) begin
        out_data_d    = blk;
        out_valid_d   = 1'b1;
        // A message ending exactly on a block boundary needs a whole pad block after it.
        out_last_d    = in_last && !(PAD_EN && cnt_q == 4'd15);
        pad_pending_d = PAD_EN && in_last && cnt_q == 4'd15;
        cnt_d         = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      pad_pending_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      pad_pending_q <= pad_pending_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
    end
  end

endmodule

// File: tb/tb_cipher_block_packer.sv
// tb/tb_cipher_block_packer.sv - randomized self-checking bench for both PAD_EN settings
module tb_cipher_block_packer;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data   [2];
  logic         in_valid  [2];
  logic         in_last   [2];
  logic         in_ready  [2];
  logic [127:0] out_data  [2];
  logic         out_valid [2];
  logic         out_last  [2];
  logic         out_ready [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit rand_rdy = 0;

  logic [7:0]   mq  [2][$];
  logic [128:0] exq [2][$];

  cipher_block_packer #(.PAD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0])
  );

  cipher_block_packer #(.PAD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: collect bytes; a block closes at 16 bytes or at in_last, padded by PKCS#7 or zero-filled.
  task automatic model_accept(input int s, input logic [7:0] b, input logic last);
    int n;
    logic [127:0] blk;
    bit pad_en;
    mq[s].push_back(b);
    if (last || mq[s].size() == 16) begin
      n = mq[s].size();
      pad_en = (s == 1);
      for (int i = 0; i < 16; i++)
        blk[127-8*i -: 8] = (i < n) ? mq[s][i] : (pad_en ? 8'(16 - n) : 8'h00);
      exq[s].push_back({last && !(pad_en && n == 16), blk});
      if (pad_en && last && n == 16) exq[s].push_back({1'b1, {16{8'h10}}});
      mq[s].delete();
    end
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input logic last, input bit gaps);
    int budget;
    bit done;
    budget = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid[s] = 1'b0;
        in_last[s]  = 1'($urandom_range(0, 1));
        in_data[s]  = 8'($urandom);
      end else begin
        in_valid[s] = 1'b1;
        in_data[s]  = b;
        in_last[s]  = last;
        if (in_ready[s]) begin
          done = 1;
          model_accept(s, b, last);
        end
      end
      budget++;
      if (!done && budget > 300) begin
        chk("in_ready_timeout", 129'(0), 129'(1));
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    in_last[s]  = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      out_ready[0] = ($urandom_range(0, 3) != 0);
      out_ready[1] = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst && out_valid[s] && out_ready[s]) begin
        if (exq[s].size() == 0) chk("unexpected_block", {out_last[s], out_data[s]}, 129'(0));
        else chk("block", {out_last[s], out_data[s]}, exq[s].pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_data[s] = '0; in_valid[s] = 0; in_last[s] = 0; out_ready[s] = 1;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_data", 129'(out_data[s]), 129'(0));
      chk("rst_out_valid", 129'(out_valid[s]), 129'(0));
      chk("rst_out_last", 129'(out_last[s]), 129'(0));
      chk("rst_in_ready", 129'(in_ready[s]), 129'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", 129'(in_ready[1]), 129'(1));

    // Full block, no last, with one-cycle latency
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 1'b0, 0);
    chk("latency_valid", 129'(out_valid[1]), 129'(1));
    chk("latency_last", 129'(out_last[1]), 129'(0));
    chk("latency_in_ready", 129'(in_ready[1]), 129'(0));
    repeat (3) @(posedge clk);

    // Partial last block with padding
    for (int i = 0; i < 5; i++) send_byte(1, 8'hAA, i == 4, 0);
    chk("partial_pad", {out_last[1], out_data[1]}, {1'b1, 128'hAAAAAAAAAA0B0B0B0B0B0B0B0B0B0B0B});
    repeat (3) @(posedge clk);

    // Exact 16-byte message: data block, then a whole pad block
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), i == 15, 0);
    chk("exact_data_last", 129'(out_last[1]), 129'(0));
    chk("exact_in_ready0", 129'(in_ready[1]), 129'(0));
    @(posedge clk); #1;
    chk("pad_block", {out_valid[1], out_last[1], out_data[1]}, {2'b11, {16{8'h10}}});
    chk("exact_in_ready1", 129'(in_ready[1]), 129'(0));
    @(posedge clk); #1;
    chk("pad_done_valid", 129'(out_valid[1]), 129'(0));
    chk("pad_done_in_ready", 129'(in_ready[1]), 129'(1));

    // Zero-fill without an extra block
    send_byte(0, 8'h11, 0, 0);
    send_byte(0, 8'h22, 0, 0);
    send_byte(0, 8'h33, 1, 0);
    chk("zero_fill", {out_last[0], out_data[0]}, {1'b1, 128'h11223300000000000000000000000000});
    @(posedge clk); #1;
    chk("zero_fill_no_extra", 129'(out_valid[0]), 129'(0));

    // Backpressure
    out_ready[1] = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(1, 8'(8'h40 + i), 1'b0, 0);
    held = out_data[1];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 129'(out_valid[1]), 129'(1));
      chk("bp_data", 129'(out_data[1]), 129'(held));
      chk("bp_in_ready", 129'(in_ready[1]), 129'(0));
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 129'(in_ready[1]), 129'(1));

    // Reset mid-block
    for (int i = 0; i < 7; i++) send_byte(1, 8'hEE, 1'b0, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    mq[0].delete(); mq[1].delete();
    exq[0].delete(); exq[1].delete();
    #1;
    chk("midrst_out", {out_valid[1], out_last[1], out_data[1]}, 130'(0) >> 1);
    chk("midrst_in_ready", 129'(in_ready[1]), 129'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 1'b0, 0);
    chk("after_rst_block", {out_last[1], out_data[1]}, {1'b0, 128'h000102030405060708090A0B0C0D0E0F});
    repeat (3) @(posedge clk);

    // Randomized messages with gaps and random backpressure
    rand_rdy = 1;
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 8; m++) begin
        int len;
        len = $urandom_range(1, 40);
        for (int i = 0; i < len; i++) send_byte(s, 8'($urandom), i == len - 1, 1);
      end
    end
    rand_rdy = 0;
    @(posedge clk); #1;
    out_ready[0] = 1; out_ready[1] = 1;
    repeat (20) @(posedge clk);
    chk("drain0", 129'(exq[0].size()), 129'(0));
    chk("drain1", 129'(exq[1].size()), 129'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cipher_block_packer.md
Name: cipher_block_packer

Overview:
- Upstream feeder for the 128-bit XOR cipher stage.
- Accepts a byte stream with valid/ready/last and packs 16 bytes into one 128-bit plaintext block, byte 0 in bits [127:120].
- Optionally applies PKCS#7 padding to the final block of a message.
- Presents each block on a valid/ready output. The cipher's plaintext input is driven from out_data.

Parameters:
- PAD_EN, 1: 1 = PKCS#7 padding on message end; 0 = zero-fill the final partial block, with no extra block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- in_data  input  8  plaintext byte
- in_valid  input  1  in_data is valid
- in_last  input  1  byte is the final byte of the message; qualified by in_valid
- in_ready  output  1  packer accepts a byte this cycle
- out_data  output  128  packed plaintext block
- out_valid  output  1  out_data is valid
- out_last  output  1  block is the final block of the message
- out_ready  input  1  downstream accepts the block

Behaviour:
- Reset (rst low, asynchronous): out_data=0, out_valid=0, out_last=0, byte count=0, pad_pending=0, buffer=0. in_ready is low while rst is low.
- Reset mid-block discards partial bytes and any held output block. The first byte after release lands at [127:120].
- Internal state:
  - buffer [127:0]
  - count 0..15
  - pad_pending flag
  - output register: one block deep
- in_ready = !out_valid && !pad_pending. Purely registered state; no combinational path from out_ready.
- Byte accept (in_valid && in_ready): byte is written to buffer bits [127-8*count -: 8].
- Normal case (count<15, !in_last): count increments; no output.
- Full block (count==15, !in_last): out_data <= full buffer, out_valid<=1, out_last<=0, count<=0.
- Partial last block (in_last with count<15): n = count+1 bytes are valid.
  - PAD_EN=1: the remaining 16-n bytes are filled with value (16-n).
  - PAD_EN=0: the remaining bytes are filled with 0x00.
  - Then out_valid<=1, out_last<=1, count<=0.
- Full last block (in_last with count==15):
  - PAD_EN=0: block is emitted with out_last=1.
  - PAD_EN=1: block is emitted with out_last=0 and pad_pending<=1.
- Pad block: when the pending data block handshakes (out_valid && out_ready) and pad_pending=1, the next cycle has out_data=all bytes 0x10, out_valid=1, out_last=1, and pad_pending<=0.
- Output handshake: a block transfers when out_valid && out_ready. out_valid then clears the next cycle, unless a pad block is loaded.
- While out_valid && !out_ready, out_data and out_last hold stable.
- Latency: the 16th byte accepted at cycle t gives out_valid=1 at t+1.
- Throughput: one byte per cycle, with one bubble per block (in_ready low while the block is held, minimum 1 cycle).
- Buffer bytes beyond the written position are never exposed; padding or zero-fill always overwrites them.
- in_last with in_valid low is ignored.
- An empty message (no bytes) produces no block.

Test Plan:
- Full block, PAD_EN=1:
  - Stimulus: bytes 0x00..0x0F, in_last=0, out_ready=1.
  - Response: one block 0x000102030405060708090A0B0C0D0E0F with out_last=0; out_valid asserted the cycle after the 16th accept.
- Partial last block, PAD_EN=1:
  - Stimulus: 5 bytes 0xAA, the last with in_last=1.
  - Response: block 0xAAAAAAAAAA0B0B0B0B0B0B0B0B0B0B0B with out_last=1.
- Exact 16-byte message, PAD_EN=1:
  - Stimulus: bytes 0x00..0x0F, the 16th with in_last=1.
  - Response: data block with out_last=0, then a block of sixteen 0x10 bytes with out_last=1. in_ready stays low until the pad block handshakes.
- Partial last block, PAD_EN=0:
  - Stimulus: 3 bytes 0x11,0x22,0x33 with in_last on the third.
  - Response: 0x11223300000000000000000000000000 with out_last=1, and no extra block.
- Backpressure:
  - Stimulus: after a full block, hold out_ready=0 for 10 cycles.
  - Response: out_valid stays 1, out_data is unchanged, in_ready=0 throughout. On out_ready=1 the block transfers and in_ready returns to 1 the next cycle.
- Reset mid-block:
  - Stimulus: accept 7 bytes, pulse rst low asynchronously (between clock edges), release, then send 0x00..0x0F.
  - Response: all outputs are 0 during reset; the next block is exactly 0x000102...0F, with no residue from the earlier 7 bytes.
